// File: rtl/trn_tx_arb.sv
// trn_tx_arb: packet-atomic round-robin arbiter sharing the TRN Tx port among N_REQ sources.
// Also hands the core its config-completion slots, only ever between packets.
module trn_tx_arb #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned BUF_MIN = 1
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  trn_lnk_up_n,
  input  logic [5:0]            trn_tbuf_av,
  input  logic                  trn_tdst_rdy_n,
  input  logic                  trn_tcfg_req_n,
  output logic                  trn_tcfg_gnt_n,
  input  logic [64*N_REQ-1:0]   req_td,
  input  logic [N_REQ-1:0]      req_trem_n,
  input  logic [N_REQ-1:0]      req_tsof_n,
  input  logic [N_REQ-1:0]      req_teof_n,
  input  logic [N_REQ-1:0]      req_tsrc_rdy_n,
  input  logic [N_REQ-1:0]      req_tsrc_dsc_n,
  input  logic [N_REQ-1:0]      req_terrfwd_n,
  output logic [N_REQ-1:0]      req_tdst_rdy_n,
  output logic [63:0]           trn_td,
  output logic                  trn_trem_n,
  output logic                  trn_tsof_n,
  output logic                  trn_teof_n,
  output logic                  trn_tsrc_rdy_n,
  output logic                  trn_tsrc_dsc_n,
  output logic                  trn_terrfwd_n,
  output logic                  trn_tstr_n,
  output logic [N_REQ-1:0]      grant
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPkt  = 2'd1;
  localparam logic [1:0] StCfg  = 2'd2;

  localparam logic [5:0]    BufMin  = 6'(BUF_MIN);
  localparam logic [PW-1:0] LastIdx = PW'(N_REQ - 1);

  logic [1:0]       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    gidx_q, gidx_d;
  logic [PW-1:0]    rr_q, rr_d;
  logic             cfg_gnt_n_q, cfg_gnt_n_d;

  logic             link_up;
  logic [N_REQ-1:0] cand;
  logic             pick_found;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;
  int unsigned      pick_j;
  logic             pkt_on;
  logic             beat;
  logic             pkt_end;
  logic [63:0]      td_arr [N_REQ];

  assign link_up = ~trn_lnk_up_n;
  assign cand    = ~req_tsrc_rdy_n & ~req_tsof_n;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_td
    assign td_arr[gi] = req_td[64*gi +: 64];
  end

  // Rotating-priority search: first candidate at or after the RR pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_j     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      pick_j = (32'(rr_q) + k) % N_REQ;
      if (!pick_found && cand[PW'(pick_j)]) begin
        pick_found = 1'b1;
        pick_idx   = PW'(pick_j);
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      pick_oh[i] = (pick_idx == PW'(i));
    end
  end

  assign pkt_on  = link_up && (state_q == StPkt);
  assign beat    = pkt_on && !req_tsrc_rdy_n[gidx_q] && !trn_tdst_rdy_n;
  // A dsc ends the packet whether or not the beat carrying it transfers.
  assign pkt_end = pkt_on && ((beat && !req_teof_n[gidx_q]) || !req_tsrc_dsc_n[gidx_q]);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    cfg_gnt_n_d = cfg_gnt_n_q;
    if (!link_up) begin
      state_d     = StIdle;
      grant_d     = '0;
      gidx_d      = '0;
      rr_d        = '0;
      cfg_gnt_n_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (!trn_tcfg_req_n) begin
            cfg_gnt_n_d = 1'b0;
            state_d     = StCfg;
          end else if (pick_found && (trn_tbuf_av >= BufMin)) begin
            grant_d = pick_oh;
            gidx_d  = pick_idx;
            state_d = StPkt;
          end
        end
        StCfg: begin
          if (trn_tcfg_req_n) begin
            cfg_gnt_n_d = 1'b1;
            state_d     = StIdle;
          end
        end
        StPkt: begin
          if (pkt_end) begin
            state_d = StIdle;
            grant_d = '0;
            rr_d    = (gidx_q == LastIdx) ? '0 : gidx_q + 1'b1;
          end
        end
        default: begin
          state_d     = StIdle;
          grant_d     = '0;
          cfg_gnt_n_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_q        <= '0;
      cfg_gnt_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_q        <= rr_d;
      cfg_gnt_n_q <= cfg_gnt_n_d;
    end
  end

  // Shared port is a pure mux of the owner; everything idles whenever the link is down.
  always_comb begin
    trn_td         = '0;
    trn_trem_n     = 1'b1;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    trn_tsrc_dsc_n = 1'b1;
    trn_terrfwd_n  = 1'b1;
    req_tdst_rdy_n = '1;
    if (pkt_on) begin
      trn_td         = td_arr[gidx_q];
      trn_trem_n     = req_trem_n[gidx_q];
      trn_tsof_n     = req_tsof_n[gidx_q];
      trn_teof_n     = req_teof_n[gidx_q];
      trn_tsrc_rdy_n = req_tsrc_rdy_n[gidx_q];
      trn_tsrc_dsc_n = req_tsrc_dsc_n[gidx_q];
      trn_terrfwd_n  = req_terrfwd_n[gidx_q];
      req_tdst_rdy_n = ~grant_q | {N_REQ{trn_tdst_rdy_n}};
    end
  end

  assign grant          = link_up ? grant_q : '0;
  assign trn_tcfg_gnt_n = cfg_gnt_n_q | trn_lnk_up_n;
  assign trn_tstr_n     = 1'b1;

endmodule

// File: tb/tb_trn_tx_arb.sv
// Bench for trn_tx_arb: queued requester drivers, an expected-beat scoreboard and a monitor
// that checks every beat crossing the shared port.
module tb_trn_tx_arb;

  typedef struct packed {
    logic [63:0] d;
    logic        rem_n;
    logic        sof_n;
    logic        eof_n;
    logic        dsc_n;
    logic        err_n;
  } beat_t;

  typedef struct packed {
    logic [1:0] g;
    beat_t      b;
  } exp_t;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         trn_lnk_up_n;
  logic [5:0]   trn_tbuf_av;
  logic         trn_tdst_rdy_n;
  logic         trn_tcfg_req_n;
  logic         trn_tcfg_gnt_n;
  logic [127:0] req_td;
  logic [1:0]   req_trem_n, req_tsof_n, req_teof_n, req_tsrc_rdy_n;
  logic [1:0]   req_tsrc_dsc_n, req_terrfwd_n, req_tdst_rdy_n;
  logic [63:0]  trn_td;
  logic         trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic         trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n;
  logic [1:0]   grant;

  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];
  int    checks   = 0;
  int    failures = 0;

  always #5 sys_clk = ~sys_clk;

  trn_tx_arb #(.N_REQ(2), .BUF_MIN(1)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .trn_lnk_up_n   (trn_lnk_up_n),
    .trn_tbuf_av    (trn_tbuf_av),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tcfg_req_n (trn_tcfg_req_n),
    .trn_tcfg_gnt_n (trn_tcfg_gnt_n),
    .req_td         (req_td),
    .req_trem_n     (req_trem_n),
    .req_tsof_n     (req_tsof_n),
    .req_teof_n     (req_teof_n),
    .req_tsrc_rdy_n (req_tsrc_rdy_n),
    .req_tsrc_dsc_n (req_tsrc_dsc_n),
    .req_terrfwd_n  (req_terrfwd_n),
    .req_tdst_rdy_n (req_tdst_rdy_n),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tsrc_dsc_n (trn_tsrc_dsc_n),
    .trn_terrfwd_n  (trn_terrfwd_n),
    .trn_tstr_n     (trn_tstr_n),
    .grant          (grant)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t make_beat(input int k, input int n, input logic [63:0] base,
                                      input int dsc_at);
    beat_t b;
    b.d     = base + 64'(k);
    b.rem_n = ~k[0];
    b.sof_n = !(k == 0);
    b.eof_n = !((k == n - 1) && (dsc_at < 0));
    b.dsc_n = !(k == dsc_at);
    b.err_n = !(k == 2);
    return b;
  endfunction

  task automatic push_src(input int r, input int n, input logic [63:0] base, input int dsc_at);
    for (int k = 0; k < n; k++) begin
      if (r == 0) q0.push_back(make_beat(k, n, base, dsc_at));
      else        q1.push_back(make_beat(k, n, base, dsc_at));
    end
  endtask

  task automatic push_exp(input int r, input int nexp, input int n, input logic [63:0] base,
                          input int dsc_at);
    exp_t e;
    for (int k = 0; k < nexp; k++) begin
      e.g = (r == 0) ? 2'b01 : 2'b10;
      e.b = make_beat(k, n, base, dsc_at);
      exp_q.push_back(e);
    end
  endtask

  task automatic present(input logic ri, input logic act, input beat_t b);
    if (ri) req_td[127:64] = act ? b.d : 64'd0;
    else    req_td[63:0]   = act ? b.d : 64'd0;
    req_tsrc_rdy_n[ri] = !act;
    req_trem_n[ri]     = act ? b.rem_n : 1'b1;
    req_tsof_n[ri]     = act ? b.sof_n : 1'b1;
    req_teof_n[ri]     = act ? b.eof_n : 1'b1;
    req_tsrc_dsc_n[ri] = act ? b.dsc_n : 1'b1;
    req_terrfwd_n[ri]  = act ? b.err_n : 1'b1;
  endtask

  // Requester drivers: hold the head beat until it is accepted, then move to the next.
  initial begin : drv
    logic  x0, x1;
    beat_t nb;
    nb = '0;
    present(1'b0, 1'b0, nb);
    present(1'b1, 1'b0, nb);
    forever begin
      @(negedge sys_clk);
      x0 = !req_tsrc_rdy_n[0] && !req_tdst_rdy_n[0];
      x1 = !req_tsrc_rdy_n[1] && !req_tdst_rdy_n[1];
      @(posedge sys_clk);
      #1;
      if (x0 && q0.size() > 0) void'(q0.pop_front());
      if (x1 && q1.size() > 0) void'(q1.pop_front());
      if (q0.size() > 0) present(1'b0, 1'b1, q0[0]); else present(1'b0, 1'b0, nb);
      if (q1.size() > 0) present(1'b1, 1'b1, q1[0]); else present(1'b1, 1'b0, nb);
    end
  end

  initial begin : mon
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got td %h grant %b expected no beat", trn_td, grant);
        end else begin
          e = exp_q.pop_front();
          chk("beat_grant", 64'(grant), 64'(e.g));
          chk("beat_td", trn_td, e.b.d);
          chk("beat_ctl", 64'({trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_dsc_n, trn_terrfwd_n}),
              64'({e.b.rem_n, e.b.sof_n, e.b.eof_n, e.b.dsc_n, e.b.err_n}));
        end
      end
      if (!grant[0]) chk("other_dst_rdy0", 64'(req_tdst_rdy_n[0]), 64'd1);
      else           chk("own_dst_rdy0", 64'(req_tdst_rdy_n[0]), 64'(trn_tdst_rdy_n));
      if (!grant[1]) chk("other_dst_rdy1", 64'(req_tdst_rdy_n[1]), 64'd1);
      else           chk("own_dst_rdy1", 64'(req_tdst_rdy_n[1]), 64'(trn_tdst_rdy_n));
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0) && n < 400) begin
      @(negedge sys_clk);
      #2;
      n++;
    end
    chk({nm, "_timeout"}, 64'(n < 400), 64'd1);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_grant"}, 64'(grant), 64'd0);
    chk({nm, "_src_rdy"}, 64'(trn_tsrc_rdy_n), 64'd1);
    chk({nm, "_cfg_gnt"}, 64'(trn_tcfg_gnt_n), 64'd1);
    chk({nm, "_td"}, trn_td, 64'd0);
    chk({nm, "_dst_rdy"}, 64'(req_tdst_rdy_n), 64'd3);
  endtask

  initial begin : main
    sys_rst        = 1'b1;
    trn_lnk_up_n   = 1'b0;
    trn_tbuf_av    = 6'd8;
    trn_tdst_rdy_n = 1'b0;
    trn_tcfg_req_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_idle("reset");
    chk("reset_tstr", 64'(trn_tstr_n), 64'd1);
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);

    // 1: single 3-beat TLP from req0
    push_src(0, 3, 64'h1111_0000_0000_0000, -1);
    push_exp(0, 3, 3, 64'h1111_0000_0000_0000, -1);
    @(negedge sys_clk);
    chk("t1_grant_not_yet", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t1_grant", 64'(grant), 64'd1);
    wait_done("t1");
    chk("t1_release", 64'(grant), 64'd0);

    // 2: both sources, two 2-beat TLPs each; pointer sits at 1 so req1 goes first
    push_src(0, 2, 64'h2A00_0000_0000_0000, -1);
    push_src(0, 2, 64'h2C00_0000_0000_0000, -1);
    push_src(1, 2, 64'h2B00_0000_0000_0000, -1);
    push_src(1, 2, 64'h2D00_0000_0000_0000, -1);
    push_exp(1, 2, 2, 64'h2B00_0000_0000_0000, -1);
    push_exp(0, 2, 2, 64'h2A00_0000_0000_0000, -1);
    push_exp(1, 2, 2, 64'h2D00_0000_0000_0000, -1);
    push_exp(0, 2, 2, 64'h2C00_0000_0000_0000, -1);
    repeat (2) @(negedge sys_clk);
    chk("t2_first_grant", 64'(grant), 64'd2);
    wait_done("t2");

    // 3: core stalls 4 cycles mid-packet
    push_src(0, 4, 64'h3300_0000_0000_0000, -1);
    push_exp(0, 4, 4, 64'h3300_0000_0000_0000, -1);
    repeat (2) @(negedge sys_clk);
    @(posedge sys_clk); #1 trn_tdst_rdy_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("t3_td_hold", trn_td, 64'h3300_0000_0000_0001);
      chk("t3_dst_rdy_hold", 64'(req_tdst_rdy_n), 64'd3);
      chk("t3_src_rdy", 64'(trn_tsrc_rdy_n), 64'd0);
    end
    #1 trn_tdst_rdy_n = 1'b0;
    wait_done("t3");

    // 4: config request during req1's packet, req0 pending behind it
    push_src(1, 3, 64'h4400_0000_0000_0000, -1);
    push_exp(1, 3, 3, 64'h4400_0000_0000_0000, -1);
    repeat (2) @(negedge sys_clk);
    chk("t4_grant", 64'(grant), 64'd2);
    push_src(0, 2, 64'h4500_0000_0000_0000, -1);
    push_exp(0, 2, 2, 64'h4500_0000_0000_0000, -1);
    @(posedge sys_clk); #1 trn_tcfg_req_n = 1'b0;
    @(negedge sys_clk);
    chk("t4_no_cfg_mid_pkt", 64'(trn_tcfg_gnt_n), 64'd1);
    @(negedge sys_clk);
    chk("t4_no_cfg_at_eof", 64'(trn_tcfg_gnt_n), 64'd1);
    @(negedge sys_clk);
    chk("t4_idle_gap_cfg", 64'(trn_tcfg_gnt_n), 64'd1);
    chk("t4_idle_gap_grant", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t4_cfg_gnt", 64'(trn_tcfg_gnt_n), 64'd0);
    chk("t4_req0_waits", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t4_req0_still_waits", 64'(grant), 64'd0);
    @(posedge sys_clk); #1 trn_tcfg_req_n = 1'b1;
    @(negedge sys_clk);
    chk("t4_cfg_held", 64'(trn_tcfg_gnt_n), 64'd0);
    @(negedge sys_clk);
    chk("t4_cfg_released", 64'(trn_tcfg_gnt_n), 64'd1);
    chk("t4_cfg_exit_grant", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t4_req0_granted", 64'(grant), 64'd1);
    wait_done("t4");

    // 5: no buffer credit, then exactly BUF_MIN
    @(posedge sys_clk); #1 trn_tbuf_av = 6'd0;
    @(negedge sys_clk);
    push_src(0, 1, 64'h5500_0000_0000_0000, -1);
    push_exp(0, 1, 1, 64'h5500_0000_0000_0000, -1);
    @(negedge sys_clk);
    chk("t5_no_buf_a", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t5_no_buf_b", 64'(grant), 64'd0);
    @(posedge sys_clk); #1 trn_tbuf_av = 6'd1;
    @(negedge sys_clk);
    chk("t5_buf_latency", 64'(grant), 64'd0);
    @(negedge sys_clk);
    chk("t5_buf_grant", 64'(grant), 64'd1);
    trn_tbuf_av = 6'd8;
    wait_done("t5");

    // 6a: link drops mid-packet; a non-SOF beat after link-up is ignored
    push_src(0, 4, 64'h6600_0000_0000_0000, -1);
    push_exp(0, 1, 4, 64'h6600_0000_0000_0000, -1);
    repeat (2) @(negedge sys_clk);
    chk("t6a_grant", 64'(grant), 64'd1);
    @(posedge sys_clk); #1 trn_lnk_up_n = 1'b1;
    #1 check_idle("t6a_link_down_now");
    @(negedge sys_clk);
    check_idle("t6a_link_down");
    @(negedge sys_clk);
    @(posedge sys_clk); #1 trn_lnk_up_n = 1'b0;
    @(negedge sys_clk);
    check_idle("t6a_nosof_a");
    @(negedge sys_clk);
    check_idle("t6a_nosof_b");
    q0.delete();
    @(negedge sys_clk);
    // link-down cleared the pointer, so req0 wins the tie
    push_src(0, 1, 64'h6700_0000_0000_0000, -1);
    push_src(1, 1, 64'h6800_0000_0000_0000, -1);
    push_exp(0, 1, 1, 64'h6700_0000_0000_0000, -1);
    push_exp(1, 1, 1, 64'h6800_0000_0000_0000, -1);
    wait_done("t6a");

    // 6b: asynchronous reset mid-packet
    push_src(1, 3, 64'h6900_0000_0000_0000, -1);
    push_exp(1, 2, 3, 64'h6900_0000_0000_0000, -1);
    repeat (3) @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1 check_idle("t6b_async_rst");
    q1.delete();
    @(posedge sys_clk); #1 sys_rst = 1'b0;
    @(negedge sys_clk);
    check_idle("t6b_after_rst_a");
    @(negedge sys_clk);
    check_idle("t6b_after_rst_b");

    // 7: discontinue without EOF ends the packet
    push_src(1, 2, 64'h7700_0000_0000_0000, 1);
    push_exp(1, 2, 2, 64'h7700_0000_0000_0000, 1);
    repeat (2) @(negedge sys_clk);
    chk("t7_grant", 64'(grant), 64'd2);
    @(negedge sys_clk);
    chk("t7_dsc_pass", 64'(trn_tsrc_dsc_n), 64'd0);
    @(negedge sys_clk);
    chk("t7_dsc_ends", 64'(grant), 64'd0);
    wait_done("t7");

    repeat (3) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
